square_frame_ctrl: RTL

Per-frame motion and score sequencer for the on-screen square. Samples the frame-end strobe from the VGA timing generator and arbitrates between the board switches and held PS/2 keys to pick one direction per frame. Clamps the new position to the visible area, updates the two goal scores, and publishes a consistent bounding box to the pixel colour mux. Sits between Ps2Interface/switches and the colour path of the VGA top level.

---
 rtl/square_pkg.sv | 42 ++++
 rtl/ps2_key_tracker.sv | 47 ++++
 rtl/square_frame_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/square_pkg.sv
// Shared types and constants for the on-screen square frame sequencer.
package square_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    MOVE   = 3'd2,
    SCORE  = 3'd3,
    COMMIT = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    LEFT  = 3'd1,
    RIGHT = 3'd2,
    UP    = 3'd3,
    DOWN  = 3'd4
  } dir_e;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h1C;
  localparam logic [7:0] SC_RIGHT = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h1D;
  localparam logic [7:0] SC_DOWN  = 8'h1B;

  // Bit positions shared by sw and the held-key vector: {left,right,up,down}
  localparam int KEY_LEFT  = 3;
  localparam int KEY_RIGHT = 2;
  localparam int KEY_UP    = 1;
  localparam int KEY_DOWN  = 0;

  function automatic dir_e pick_dir(input logic [3:0] req);
    dir_e d;
    d = NONE;
    if (req[KEY_LEFT])       d = LEFT;
    else if (req[KEY_RIGHT]) d = RIGHT;
    else if (req[KEY_UP])    d = UP;
    else if (req[KEY_DOWN])  d = DOWN;
    return d;
  endfunction

endpackage

// File: rtl/ps2_key_tracker.sv
// Tracks which movement keys are held, from a PS/2 make/break scan-code stream.
module ps2_key_tracker
  import square_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic [3:0] held
);

  logic       brk_q, brk_d;
  logic [3:0] held_q, held_d;

  always_comb begin
    brk_d  = brk_q;
    held_d = held_q;
    if (key_valid) begin
      if (key_code == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        // Any non-break byte ends a pending break, even an unrecognised one.
        brk_d = 1'b0;
        case (key_code)
          SC_LEFT:  held_d[KEY_LEFT]  = ~brk_q;
          SC_RIGHT: held_d[KEY_RIGHT] = ~brk_q;
          SC_UP:    held_d[KEY_UP]    = ~brk_q;
          SC_DOWN:  held_d[KEY_DOWN]  = ~brk_q;
          default:  held_d = held_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brk_q  <= 1'b0;
      held_q <= 4'b0000;
    end else begin
      brk_q  <= brk_d;
      held_q <= held_d;
    end
  end

  assign held = held_q;

endmodule

// File: rtl/square_frame_ctrl.sv
// Per-frame motion/score sequencer: one arbitrated step per frame tick,
// bounding box published atomically on COMMIT.
//
// state  | meaning
// IDLE   | waiting for a frame tick (or a pending one)
// ARB    | pick direction: switches first, then held keys
// MOVE   | apply step with clamp to visible area
// SCORE  | update goal scores from post-move x
// COMMIT | load all four bounds, pulse update_done next cycle
module square_frame_ctrl
  import square_pkg::*;
#(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int SQ_SIZE    = 50,
  parameter int STEP       = 1,
  parameter int INIT_X     = 270,
  parameter int INIT_Y     = 240,
  parameter int LEFT_GOAL  = 160,
  parameter int RIGHT_GOAL = 430,
  parameter int SCORE_W    = 32
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [3:0]         sw,
  input  logic               key_valid,
  input  logic [7:0]         key_code,
  output logic [9:0]         sq_left,
  output logic [9:0]         sq_right,
  output logic [8:0]         sq_top,
  output logic [8:0]         sq_bottom,
  output logic [SCORE_W-1:0] left_score,
  output logic [SCORE_W-1:0] right_score,
  output logic               busy,
  output logic               update_done
);

  localparam logic [10:0]        X_MAX   = 11'(SCREEN_W - SQ_SIZE);
  localparam logic [9:0]         Y_MAX   = 10'(SCREEN_H - SQ_SIZE);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_e state_q, state_d;
  dir_e   dir_q, dir_d;

  logic                tick_q;
  logic                tick_rise;
  logic                pending_q, pending_d;
  logic [9:0]          x_q, x_d;
  logic [8:0]          y_q, y_d;
  logic [SCORE_W-1:0]  lscore_q, lscore_d;
  logic [SCORE_W-1:0]  rscore_q, rscore_d;
  logic [9:0]          left_q, left_d, right_q, right_d;
  logic [8:0]          top_q, top_d, bottom_q, bottom_d;
  logic                done_q, done_d;

  logic [3:0]          held;
  logic [3:0]          req;
  logic [10:0]         x_inc;
  logic [9:0]          y_inc;

  ps2_key_tracker u_keys (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .held      (held)
  );

  assign tick_rise = frame_tick & ~tick_q;
  assign req       = (sw != 4'b0000) ? sw : held;
  assign x_inc     = {1'b0, x_q} + 11'(STEP);
  assign y_inc     = {1'b0, y_q} + 10'(STEP);

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    pending_d = pending_q;
    x_d       = x_q;
    y_d       = y_q;
    lscore_d  = lscore_q;
    rscore_d  = rscore_q;
    left_d    = left_q;
    right_d   = right_q;
    top_d     = top_q;
    bottom_d  = bottom_q;
    done_d    = 1'b0;

    // Only one frame may queue behind the running update; extra rises are lost.
    if (tick_rise && (state_q != IDLE)) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (pending_q || tick_rise) begin
          state_d   = ARB;
          pending_d = 1'b0;
        end
      end
      ARB: begin
        dir_d   = pick_dir(req);
        state_d = MOVE;
      end
      MOVE: begin
        case (dir_q)
          LEFT:    x_d = (x_q < 10'(STEP)) ? 10'd0 : x_q - 10'(STEP);
          RIGHT:   x_d = (x_inc > X_MAX) ? X_MAX[9:0] : x_inc[9:0];
          UP:      y_d = (y_q < 9'(STEP)) ? 9'd0 : y_q - 9'(STEP);
          DOWN:    y_d = (y_inc > Y_MAX) ? Y_MAX[8:0] : y_inc[8:0];
          default: begin
            x_d = x_q;
            y_d = y_q;
          end
        endcase
        state_d = SCORE;
      end
      SCORE: begin
        if ((x_q < 10'(LEFT_GOAL)) && (rscore_q != SCORE_MAX))
          rscore_d = rscore_q + SCORE_W'(1);
        if ((x_q > 10'(RIGHT_GOAL)) && (lscore_q != SCORE_MAX))
          lscore_d = lscore_q + SCORE_W'(1);
        state_d = COMMIT;
      end
      COMMIT: begin
        left_d   = x_q;
        right_d  = x_q + 10'(SQ_SIZE);
        top_d    = y_q;
        bottom_d = y_q + 9'(SQ_SIZE);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      dir_q     <= NONE;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
      x_q       <= 10'(INIT_X);
      y_q       <= 9'(INIT_Y);
      lscore_q  <= '0;
      rscore_q  <= '0;
      left_q    <= 10'(INIT_X);
      right_q   <= 10'(INIT_X + SQ_SIZE);
      top_q     <= 9'(INIT_Y);
      bottom_q  <= 9'(INIT_Y + SQ_SIZE);
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      tick_q    <= frame_tick;
      pending_q <= pending_d;
      x_q       <= x_d;
      y_q       <= y_d;
      lscore_q  <= lscore_d;
      rscore_q  <= rscore_d;
      left_q    <= left_d;
      right_q   <= right_d;
      top_q     <= top_d;
      bottom_q  <= bottom_d;
      done_q    <= done_d;
    end
  end

  assign sq_left     = left_q;
  assign sq_right    = right_q;
  assign sq_top      = top_q;
  assign sq_bottom   = bottom_q;
  assign left_score  = lscore_q;
  assign right_score = rscore_q;
  assign busy        = (state_q != IDLE);
  assign update_done = done_q;

endmodule
